// File: rtl/sdram_host_port_if.sv
// Bundles the host request/response handshake and the SDRAM controller command
// interface used by sdram_host_port.
interface sdram_host_port_if #(
  parameter int unsigned HADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH  = 16
);
  // Host side
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [HADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   rsp_valid;
  logic [DATA_WIDTH-1:0]  rsp_rdata;
  logic                   timeout_err;
  // Controller side
  logic [HADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0]  data_input;
  logic                   rd_enable;
  logic                   wr_enable;
  logic                   busy;
  logic [DATA_WIDTH-1:0]  data_output;

  // Environment view: drives requests and plays the controller.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, busy, data_output,
    input  req_ready, rsp_valid, rsp_rdata, timeout_err,
    input  haddr, data_input, rd_enable, wr_enable
  );

  // Host port view.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, busy, data_output,
    output req_ready, rsp_valid, rsp_rdata, timeout_err,
    output haddr, data_input, rd_enable, wr_enable
  );
endinterface

// File: rtl/sdram_host_port.sv
// Host front end for the SDRAM controller: queues single-word requests, issues them one at a
// time on the enable/busy handshake and returns read data on a one-cycle response strobe.
module sdram_host_port #(
  parameter int unsigned HADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  sdram_host_port_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);

  typedef struct packed {
    logic                   we;
    logic [HADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]  wdata;
  } req_t;

  typedef enum logic [1:0] {StIdle, StIssue, StAck, StBusy} state_e;

  req_t                   mem_q [FIFO_DEPTH];
  req_t                   mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  state_e                 state_q, state_d;
  logic [AckW-1:0]        ack_cnt_q, ack_cnt_d;
  logic                   op_we_q, op_we_d;
  logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [DATA_WIDTH-1:0]  data_input_q, data_input_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   timeout_err_q, timeout_err_d;

  logic req_ready;
  logic push;
  logic pop;

  assign req_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push      = bus.req_valid && req_ready;
  // Never start an operation while the controller is busy (e.g. refreshing).
  assign pop       = (state_q == StIdle) && (count_q != '0) && !bus.busy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ack_cnt_d     = ack_cnt_q;
    op_we_d       = op_we_q;
    haddr_d       = haddr_q;
    data_input_d  = data_input_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          op_we_d      = mem_q[rd_ptr_q].we;
          haddr_d      = mem_q[rd_ptr_q].addr;
          data_input_d = mem_q[rd_ptr_q].wdata;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        ack_cnt_d = AckW'(ACK_TIMEOUT);
        state_d   = StAck;
      end
      StAck: begin
        if (bus.busy) begin
          state_d = StBusy;
        end else begin
          ack_cnt_d = ack_cnt_q - 1'b1;
          // Last of the ACK_TIMEOUT allowed busy samples has passed without an ack.
          if (ack_cnt_q == AckW'(1)) begin
            timeout_err_d = 1'b1;
            state_d       = StIdle;
          end
        end
      end
      StBusy: begin
        if (!bus.busy) begin
          if (!op_we_q) begin
            rsp_rdata_d = bus.data_output;
            rsp_valid_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= StIdle;
      ack_cnt_q     <= '0;
      op_we_q       <= 1'b0;
      haddr_q       <= '0;
      data_input_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      ack_cnt_q     <= ack_cnt_d;
      op_we_q       <= op_we_d;
      haddr_q       <= haddr_d;
      data_input_q  <= data_input_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Queue storage carries no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.haddr       = haddr_q;
  assign bus.data_input  = data_input_q;
  assign bus.rd_enable   = (state_q == StIssue) && !op_we_q;
  assign bus.wr_enable   = (state_q == StIssue) && op_we_q;

endmodule
